// File: rtl/sad_min_tracker_pkg.sv
// sad_min_tracker_pkg: shared definitions for the motion-estimation minimum tracker.
//   SR_LOG2_DEF   default log2 of the search range
//   SAD_W_DEF     default SAD width, matches the SAD array output
//   ZERO_BIAS_DEF default bias subtracted from the (0,0) candidate key
//   me_state_e    tracker FSM state encoding, also used by the ME controller
package sad_min_tracker_pkg;

    localparam int unsigned SR_LOG2_DEF   = 3;
    localparam int unsigned SAD_W_DEF     = 16;
    localparam int unsigned ZERO_BIAS_DEF = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } me_state_e;

endpackage

// File: rtl/sad_cand_counter.sv
// sad_cand_counter: raster-order candidate position counter for the search window.
// x is the inner loop, y the outer loop; both run 0 .. 2SR-1 and are reported
// offset by -SR as two's complement motion-vector components.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          return to candidate 0 (takes priority over inc)
//   inc          advance to the next candidate
//   cand_x/y     signed MV of the current candidate
//   is_zero      current candidate is (0,0)
//   is_last      current candidate is the final one (SR-1, SR-1)
module sad_cand_counter
    import sad_min_tracker_pkg::*;
#(
    parameter int unsigned SR_LOG2 = SR_LOG2_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SR_LOG2:0] cand_x,
    output logic [SR_LOG2:0] cand_y,
    output logic             is_zero,
    output logic             is_last
);

    localparam int unsigned CW = SR_LOG2 + 1;
    localparam logic [CW-1:0] One = CW'(1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (inc) begin
            if (&x_q) begin
                x_d = '0;
                y_d = y_q + One;
            end else begin
                x_d = x_q + One;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Subtracting SR from a 0..2SR-1 counter is just an MSB flip in CW bits.
    assign cand_x  = {~x_q[CW-1], x_q[CW-2:0]};
    assign cand_y  = {~y_q[CW-1], y_q[CW-2:0]};
    assign is_zero = (cand_x == '0) && (cand_y == '0);
    assign is_last = (&x_q) && (&y_q);

endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: tracks the minimum SAD over a raster-ordered search window
// and reports the winning motion vector with a one-cycle done pulse.
// Optional feature macro: ME_ZERO_MV_BIAS_EN -- when defined, the (0,0)
// candidate competes with key = sad - ZERO_BIAS (saturating at 0); min_sad
// still reports the raw SAD of the winner.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse; begins a scan, or aborts and restarts one in progress
//   sad_valid    sad holds the next candidate's SAD (accepted only while scanning)
//   sad          candidate SAD, unsigned
//   busy         high while scanning
//   done         one-cycle pulse; result outputs updated this cycle
//   min_sad      raw SAD of the winning candidate
//   mv_x, mv_y   winning motion vector, two's complement
module sad_min_tracker
    import sad_min_tracker_pkg::*;
#(
    parameter int unsigned SR_LOG2   = SR_LOG2_DEF,
    parameter int unsigned SAD_W     = SAD_W_DEF,
    parameter int unsigned ZERO_BIAS = ZERO_BIAS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] min_sad,
    output logic [SR_LOG2:0] mv_x,
    output logic [SR_LOG2:0] mv_y
);

    me_state_e state_q, state_d;

    logic             accept;
    logic             first_q;
    logic             update;
    logic             last_beat;
    logic [SR_LOG2:0] cand_x, cand_y;
    logic             is_zero, is_last;

    logic [SAD_W-1:0] key;
    logic [SAD_W-1:0] best_key;
    logic [SAD_W-1:0] best_raw_q;
    logic [SR_LOG2:0] best_x_q, best_y_q;

    logic [SAD_W-1:0] win_raw;
    logic [SR_LOG2:0] win_x, win_y;
    logic [SAD_W-1:0] min_sad_q;
    logic [SR_LOG2:0] mv_x_q, mv_y_q;

    // A beat arriving together with start is discarded along with the old scan.
    assign accept    = (state_q == StScan) && sad_valid && !start;
    assign last_beat = accept && is_last;

    sad_cand_counter #(
        .SR_LOG2 (SR_LOG2)
    ) u_cand_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .inc     (accept),
        .cand_x  (cand_x),
        .cand_y  (cand_y),
        .is_zero (is_zero),
        .is_last (is_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StScan;
            StScan: if (last_beat) state_d = StDone;
            StDone: state_d = start ? StScan : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ME_ZERO_MV_BIAS_EN
    localparam logic [SAD_W-1:0] Bias = SAD_W'(ZERO_BIAS);

    logic [SAD_W-1:0] best_key_q;

    always_comb begin
        key = sad;
        if (is_zero) begin
            key = (sad > Bias) ? (sad - Bias) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_key_q <= '0;
        end else if (update) begin
            best_key_q <= key;
        end
    end

    assign best_key = best_key_q;
`else
    // Without the bias the key is the raw SAD, so one register serves both.
    logic unused_bias;

    assign key         = sad;
    assign best_key    = best_raw_q;
    assign unused_bias = ^{ZERO_BIAS, is_zero};
`endif

    // First beat loads unconditionally so an all-max window still yields an MV.
    assign update = accept && (first_q || (key < best_key));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
        end else if (start) begin
            first_q <= 1'b1;
        end else if (accept) begin
            first_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_raw_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else if (update) begin
            best_raw_q <= sad;
            best_x_q   <= cand_x;
            best_y_q   <= cand_y;
        end
    end

    // The final beat may itself be the winner, so bypass the working registers.
    always_comb begin
        win_raw = best_raw_q;
        win_x   = best_x_q;
        win_y   = best_y_q;
        if (update) begin
            win_raw = sad;
            win_x   = cand_x;
            win_y   = cand_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sad_q <= '0;
            mv_x_q    <= '0;
            mv_y_q    <= '0;
        end else if (last_beat) begin
            min_sad_q <= win_raw;
            mv_x_q    <= win_x;
            mv_y_q    <= win_y;
        end
    end

    assign busy    = (state_q == StScan);
    assign done    = (state_q == StDone);
    assign min_sad = min_sad_q;
    assign mv_x    = mv_x_q;
    assign mv_y    = mv_y_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb_sad_min_tracker: scoreboard bench for sad_min_tracker. Stimulus pushes the
// expected result of each completed scan; a monitor pops it when done pulses
// and otherwise checks that the reported result holds.
module tb_sad_min_tracker;

    localparam int unsigned SR_LOG2   = 3;
    localparam int unsigned SAD_W     = 16;
    localparam int unsigned ZERO_BIAS = 16;
    localparam int unsigned MVW       = SR_LOG2 + 1;
    localparam int          ROW       = 2 * (1 << SR_LOG2);
    localparam int          NCAND     = ROW * ROW;
    localparam int          ZERO_IDX  = (ROW / 2) * ROW + (ROW / 2);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sad_valid;
    logic [SAD_W-1:0] sad;
    logic             busy;
    logic             done;
    logic [SAD_W-1:0] min_sad;
    logic [MVW-1:0]   mv_x;
    logic [MVW-1:0]   mv_y;

    sad_min_tracker #(
        .SR_LOG2   (SR_LOG2),
        .SAD_W     (SAD_W),
        .ZERO_BIAS (ZERO_BIAS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sad_valid (sad_valid),
        .sad       (sad),
        .busy      (busy),
        .done      (done),
        .min_sad   (min_sad),
        .mv_x      (mv_x),
        .mv_y      (mv_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cycle;
        logic [SAD_W-1:0] sad;
        logic [MVW-1:0]   mx;
        logic [MVW-1:0]   my;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [SAD_W-1:0] sads[NCAND];
    bit               use_lit = 0;
    exp_t             lit;

    logic [SAD_W-1:0] held_sad = '0;
    logic [MVW-1:0]   held_x   = '0;
    logic [MVW-1:0]   held_y   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain argmin over the candidate list, earliest index wins ties.
    function automatic exp_t model(input int acc_cycle);
        exp_t e;
        int   best_k   = 0;
        int   best_key = 0;
        for (int k = 0; k < NCAND; k++) begin
            int key;
            key = int'(sads[k]);
`ifdef ME_ZERO_MV_BIAS_EN
            if (k == ZERO_IDX) key = (key > int'(ZERO_BIAS)) ? key - int'(ZERO_BIAS) : 0;
`endif
            if (k == 0 || key < best_key) begin
                best_key = key;
                best_k   = k;
            end
        end
        e.cycle = acc_cycle;
        e.sad   = sads[best_k];
        e.mx    = MVW'((best_k % ROW) - ROW / 2);
        e.my    = MVW'((best_k / ROW) - ROW / 2);
        return e;
    endfunction

    // Monitor: compares on done, otherwise the result outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_sad = '0;
            held_x   = '0;
            held_y   = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no scan outstanding (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cycle);
                check("min_sad", min_sad, e.sad);
                check("mv_x", mv_x, e.mx);
                check("mv_y", mv_y, e.my);
                held_sad = e.sad;
                held_x   = e.mx;
                held_y   = e.my;
            end
        end else begin
            check("hold_min_sad", min_sad, held_sad);
            check("hold_mv_x", mv_x, held_x);
            check("hold_mv_y", mv_y, held_y);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sad=0 alongside start: if wrongly accepted it would win and be visible.
    task automatic do_start(input bit with_valid);
        start     = 1'b1;
        sad_valid = with_valid;
        sad       = '0;
        tick();
        start     = 1'b0;
        sad_valid = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // gap_mode: 0 dense, 1 alternating 1/0, 2 random 0..2 idle cycles per beat.
    task automatic send_beats(input int first, input int last, input int gap_mode);
        for (int k = first; k <= last; k++) begin
            int gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                sad_valid = 1'b0;
                sad       = SAD_W'($urandom);
                tick();
            end
            sad_valid = 1'b1;
            sad       = sads[k];
            if (k == NCAND - 1) begin
                exp_t e;
                e = use_lit ? lit : model(0);
                e.cycle = cyc + 1;
                exp_q.push_back(e);
            end
            tick();
        end
        sad_valid = 1'b0;
    endtask

    task automatic run_scan(input int gap_mode);
        do_start(1'($urandom_range(0, 1)));
        send_beats(0, NCAND - 1, gap_mode);
        check("done_state_busy", busy, 0);
    endtask

    task automatic fill(input int lo, input int hi);
        for (int k = 0; k < NCAND; k++) sads[k] = SAD_W'($urandom_range(lo, hi));
    endtask

    task automatic set_lit(input logic [SAD_W-1:0] s, input int x, input int y);
        use_lit  = 1;
        lit.sad  = s;
        lit.mx   = MVW'(x);
        lit.my   = MVW'(y);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        sad_valid = 1'b0;
        sad       = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_min_sad", min_sad, 0);
        check("rst_mv_x", mv_x, 0);
        check("rst_mv_y", mv_y, 0);
        #20 rst_n = 1'b1;
        tick();

        // Reset mid-scan, then a normal full scan.
        fill(0, 65535);
        do_start(1'b0);
        send_beats(0, 99, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_min_sad", min_sad, 0);
        check("midrst_mv_x", mv_x, 0);
        check("midrst_mv_y", mv_y, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        run_scan(0);

        // Single minimum at k=37.
        for (int k = 0; k < NCAND; k++) sads[k] = 16'd1000;
        sads[37] = 16'd5;
        set_lit(16'd5, -3, -6);
        run_scan(0);

        // All maximum: first candidate must still be reported.
        for (int k = 0; k < NCAND; k++) sads[k] = 16'hFFFF;
        set_lit(16'hFFFF, -8, -8);
        run_scan(0);

        // Tie: earlier candidate kept.
        for (int k = 0; k < NCAND; k++) sads[k] = 16'd1000;
        sads[10]  = 16'd7;
        sads[200] = 16'd7;
        set_lit(16'd7, 2, -8);
        run_scan(0);
        use_lit = 0;

        // Gapped scan with ignored beats in IDLE and DONE, then the dense rerun.
        tick();
        tick();
        fill(50, 5000);
        repeat (3) begin
            sad_valid = 1'b1;
            sad       = '0;
            tick();
        end
        sad_valid = 1'b0;
        run_scan(1);
        sad_valid = 1'b1;
        sad       = '0;
        tick();
        sad_valid = 1'b0;
        repeat (3) tick();
        run_scan(0);

        // Abort at beat 120 with a minimum already seen at k=50.
        fill(100, 1000);
        sads[50] = 16'd1;
        do_start(1'b0);
        send_beats(0, 119, 0);
        fill(200, 900);
        do_start(1'b1);
        send_beats(0, NCAND - 1, 0);
        check("abort_done_busy", busy, 0);

        // Zero-MV bias case.
        for (int k = 0; k < NCAND; k++) sads[k] = 16'd500;
        sads[ZERO_IDX] = 16'd20;
        sads[0]        = 16'd10;
`ifdef ME_ZERO_MV_BIAS_EN
        set_lit(16'd20, 0, 0);
`else
        set_lit(16'd10, -8, -8);
`endif
        run_scan(0);
        use_lit = 0;

        // Random scans, narrow SAD range to provoke ties; back-to-back starts.
        for (int i = 0; i < 6; i++) begin
            fill(0, (i % 2 == 0) ? 31 : 65535);
            run_scan(2);
            if (i % 3 == 2) repeat (2) tick();
        end

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                tick();
                guard++;
            end
            if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: %0d results outstanding, expected 0", exp_q.size());
            end
        end
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
